// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates instruction and data ports onto one single-outstanding downstream port
module mem_port_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  input  logic [3:0]  imem_wmask,
  input  logic [31:0] imem_wdata,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] dfp_addr,
  output logic [3:0]  dfp_rmask,
  output logic [3:0]  dfp_wmask,
  output logic [31:0] dfp_wdata,
  input  logic [31:0] dfp_rdata,
  input  logic        dfp_resp
);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] rmask_q, rmask_d, wmask_q, wmask_d;
  logic ireq, dreq, gnt_d, gnt_i, busy, unused_ok;
  assign unused_ok = ^{imem_wmask, imem_wdata};
  always_comb begin
    ireq = |imem_rmask;
    dreq = |(dmem_rmask | dmem_wmask);
    gnt_d = state_q == IDLE && dreq && (!ireq || !RR_EN || !last_d_q);
    gnt_i = state_q == IDLE && ireq && !gnt_d;
    state_d = state_q;
    if (gnt_d) state_d = DBUSY;
    else if (gnt_i) state_d = IBUSY;
    else if (state_q != IDLE && dfp_resp) state_d = IDLE;
    last_d_d = gnt_d ? 1'b1 : gnt_i ? 1'b0 : last_d_q;
    addr_d = gnt_d ? dmem_addr : gnt_i ? imem_addr : addr_q;
    rmask_d = gnt_d ? dmem_rmask : gnt_i ? imem_rmask : rmask_q;
    wmask_d = gnt_d ? dmem_wmask : gnt_i ? 4'h0 : wmask_q;
    wdata_d = gnt_d ? dmem_wdata : gnt_i ? 32'h0 : wdata_q;
    busy = state_q != IDLE && !rst;
    dfp_addr = busy ? addr_q : 32'h0;
    dfp_rmask = busy ? rmask_q : 4'h0;
    dfp_wmask = busy ? wmask_q : 4'h0;
    dfp_wdata = busy ? wdata_q : 32'h0;
    imem_resp = busy && state_q == IBUSY && dfp_resp;
    dmem_resp = busy && state_q == DBUSY && dfp_resp;
    imem_rdata = imem_resp ? dfp_rdata : 32'h0;
    dmem_rdata = dmem_resp ? dfp_rdata : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_d_q <= 1'b0;
      addr_q <= 32'h0;
      rmask_q <= 4'h0;
      wmask_q <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      addr_q <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of both arbitration policies against a transaction model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] imem_addr = 0, imem_wdata = 0, dmem_addr = 0, dmem_wdata = 0, dfp_rdata = 0;
  logic [3:0] imem_rmask = 0, imem_wmask = 0, dmem_rmask = 0, dmem_wmask = 0;
  logic dfp_resp = 1'b0;
  logic [31:0] o_irdata[2], o_drdata[2], o_addr[2], o_wdata[2];
  logic [3:0] o_rmask[2], o_wmask[2];
  logic o_iresp[2], o_dresp[2];
  bit m_v[2], m_side[2], m_last[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic [3:0] m_rm[2], m_wm[2];
  logic [31:0] rr_seq[6] = '{32'h0, 32'h2000, 32'h0, 32'h1000, 32'h0, 32'h2000};
  logic [31:0] fp_seq[6] = '{32'h0, 32'h2000, 32'h0, 32'h2000, 32'h0, 32'h2000};
  int vectors = 0;
  int miscompares = 0;
  mem_port_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_wmask(imem_wmask), .imem_wdata(imem_wdata),
    .imem_rdata(o_irdata[0]), .imem_resp(o_iresp[0]),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(o_drdata[0]), .dmem_resp(o_dresp[0]),
    .dfp_addr(o_addr[0]), .dfp_rmask(o_rmask[0]), .dfp_wmask(o_wmask[0]), .dfp_wdata(o_wdata[0]),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );
  mem_port_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_wmask(imem_wmask), .imem_wdata(imem_wdata),
    .imem_rdata(o_irdata[1]), .imem_resp(o_iresp[1]),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(o_drdata[1]), .dmem_resp(o_dresp[1]),
    .dfp_addr(o_addr[1]), .dfp_rmask(o_rmask[1]), .dfp_wmask(o_wmask[1]), .dfp_wdata(o_wdata[1]),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );
  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  task automatic eval();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit on, ir, dr;
      on = m_v[k] && !rst;
      ir = on && !m_side[k] && dfp_resp;
      dr = on && m_side[k] && dfp_resp;
      chk("dfp_addr", k, o_addr[k], on ? m_addr[k] : 32'h0);
      chk("dfp_rmask", k, {28'h0, o_rmask[k]}, on ? {28'h0, m_rm[k]} : 32'h0);
      chk("dfp_wmask", k, {28'h0, o_wmask[k]}, on ? {28'h0, m_wm[k]} : 32'h0);
      chk("dfp_wdata", k, o_wdata[k], on ? m_wdata[k] : 32'h0);
      chk("imem_resp", k, {31'h0, o_iresp[k]}, {31'h0, ir});
      chk("dmem_resp", k, {31'h0, o_dresp[k]}, {31'h0, dr});
      if (!(on && !m_side[k] && !dfp_resp)) chk("imem_rdata", k, o_irdata[k], ir ? dfp_rdata : 32'h0);
      if (!(on && m_side[k] && !dfp_resp)) chk("dmem_rdata", k, o_drdata[k], dr ? dfp_rdata : 32'h0);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit ir, dr;
      ir = |imem_rmask;
      dr = |(dmem_rmask | dmem_wmask);
      if (rst) begin
        m_v[k] = 1'b0;
        m_last[k] = 1'b0;
      end else if (m_v[k]) begin
        if (dfp_resp) m_v[k] = 1'b0;
      end else if (ir || dr) begin
        m_side[k] = (ir && dr) ? (k == 0 ? !m_last[k] : 1'b1) : dr;
        m_v[k] = 1'b1;
        m_last[k] = m_side[k];
        m_addr[k] = m_side[k] ? dmem_addr : imem_addr;
        m_rm[k] = m_side[k] ? dmem_rmask : imem_rmask;
        m_wm[k] = m_side[k] ? dmem_wmask : 4'h0;
        m_wdata[k] = m_side[k] ? dmem_wdata : 32'h0;
      end
    end
    #1;
  endtask
  task automatic cyc();
    eval();
    tick();
  endtask
  initial begin
    cyc();
    dfp_resp = 1'b1;
    dfp_rdata = 32'h55;
    cyc();
    rst = 1'b0;
    cyc();
    dfp_resp = 1'b0;
    cyc();
    imem_addr = 32'h1ECEB000;
    imem_rmask = 4'hF;
    cyc();
    imem_addr = 32'h0;
    imem_rmask = 4'h0;
    for (int i = 0; i < 2; i++) begin
      eval();
      chk("req043_rmask", 0, {28'h0, o_rmask[0]}, 32'hF);
      chk("req043_iresp_early", 0, {31'h0, o_iresp[0]}, 32'h0);
      tick();
    end
    dfp_resp = 1'b1;
    dfp_rdata = 32'h13;
    eval();
    chk("req043_rmask", 0, {28'h0, o_rmask[0]}, 32'hF);
    chk("req043_iresp", 0, {31'h0, o_iresp[0]}, 32'h1);
    chk("req043_irdata", 0, o_irdata[0], 32'h13);
    chk("req043_dresp", 0, {31'h0, o_dresp[0]}, 32'h0);
    tick();
    dfp_resp = 1'b0;
    cyc();
    imem_addr = 32'h1000;
    imem_rmask = 4'hF;
    dmem_addr = 32'h2000;
    dmem_rmask = 4'hF;
    dmem_wmask = 4'h3;
    dmem_wdata = 32'hCAFEF00D;
    dfp_resp = 1'b1;
    dfp_rdata = 32'hA5A50001;
    for (int i = 0; i < 6; i++) begin
      eval();
      chk("rr_order", 0, o_addr[0], rr_seq[i]);
      chk("fp_order", 1, o_addr[1], fp_seq[i]);
      tick();
    end
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    cyc();
    dfp_resp = 1'b0;
    cyc();
    dmem_addr = 32'h100;
    dmem_wmask = 4'h3;
    dmem_wdata = 32'hDEADBEEF;
    cyc();
    dmem_addr = 32'h0;
    dmem_wmask = 4'h0;
    dmem_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      eval();
      chk("req046_addr", 0, o_addr[0], 32'h100);
      chk("req046_wmask", 0, {28'h0, o_wmask[0]}, 32'h3);
      chk("req046_wdata", 0, o_wdata[0], 32'hDEADBEEF);
      tick();
    end
    dfp_resp = 1'b1;
    dfp_rdata = 32'h0;
    eval();
    chk("req046_dresp", 0, {31'h0, o_dresp[0]}, 32'h1);
    tick();
    dfp_resp = 1'b0;
    cyc();
    imem_addr = 32'h40;
    imem_rmask = 4'hF;
    imem_wmask = 4'hF;
    imem_wdata = 32'hFFFFFFFF;
    cyc();
    for (int i = 0; i < 2; i++) begin
      eval();
      chk("req047_wmask", 0, {28'h0, o_wmask[0]}, 32'h0);
      chk("req047_wdata", 0, o_wdata[0], 32'h0);
      tick();
    end
    dfp_resp = 1'b1;
    dfp_rdata = $urandom;
    cyc();
    dfp_resp = 1'b0;
    imem_rmask = 4'h0;
    imem_wmask = 4'h0;
    cyc();
    dmem_addr = 32'h200;
    dmem_rmask = 4'hF;
    cyc();
    dmem_rmask = 4'h0;
    cyc();
    rst = 1'b1;
    eval();
    chk("req048_rst_rmask", 0, {28'h0, o_rmask[0]}, 32'h0);
    tick();
    rst = 1'b0;
    dfp_resp = 1'b1;
    dfp_rdata = 32'h77;
    eval();
    chk("req048_dresp", 0, {31'h0, o_dresp[0]}, 32'h0);
    chk("req048_addr", 0, o_addr[0], 32'h0);
    tick();
    dfp_resp = 1'b0;
    cyc();
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 49) == 0;
      imem_addr = $urandom;
      imem_wdata = $urandom;
      dmem_addr = $urandom;
      dmem_wdata = $urandom;
      dfp_rdata = $urandom;
      imem_rmask = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      imem_wmask = 4'($urandom);
      dmem_rmask = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      dmem_wmask = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0;
      dfp_resp = $urandom_range(0, 2) == 0;
      cyc();
    end
    rst = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
